// File: rtl/register_file.sv
// register_file: 2^r x n register file, two combinational read ports, one write port; register 0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file #(
    parameter int n = 32,
    parameter int r = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         writeEnable,
    input  logic [r-1:0] writeAddr,
    input  logic [n-1:0] writeData,
    input  logic [r-1:0] readAddr1,
    input  logic [r-1:0] readAddr2,
    output logic [n-1:0] readData1,
    output logic [n-1:0] readData2
);
    logic [n-1:0] regs [0:(1<<r)-1];
    logic         wr;

    assign wr = writeEnable && !rst && writeAddr != '0;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < (1<<r); i++) regs[i] <= '0;
        else if (wr)
            regs[writeAddr] <= writeData;

    always_comb begin
        readData1 = (rst || readAddr1 == '0) ? '0 : regs[readAddr1];
        readData2 = (rst || readAddr2 == '0) ? '0 : regs[readAddr2];
`ifdef REGFILE_BYPASS_EN
        readData1 = (wr && writeAddr == readAddr1) ? writeData : readData1;
        readData2 = (wr && writeAddr == readAddr2) ? writeData : readData2;
`endif
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed scoreboard bench for register_file.
module tb_register_file;
    logic        clk = 0;
    logic        rst;
    logic        writeEnable;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic [4:0]  readAddr1;
    logic [4:0]  readAddr2;
    logic [31:0] readData1;
    logic [31:0] readData2;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    event smp;
    int   tests = 0;
    int   fails = 0;

    register_file dut (
        .clk(clk), .rst(rst), .writeEnable(writeEnable), .writeAddr(writeAddr),
        .writeData(writeData), .readAddr1(readAddr1), .readAddr2(readAddr2),
        .readData1(readData1), .readData2(readData2)
    );

    always #5 clk = ~clk;

    always @(smp) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e = q.pop_front();
            got = (e.port == 1) ? readData1 : readData2;
            tests++;
            if (got !== e.exp) begin
                fails++;
                $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, got, e.exp);
            end
        end
    end

    task automatic chk(input string name, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] e1, input logic [31:0] e2);
        readAddr1 = a1;
        readAddr2 = a2;
        #1;
        q.push_back('{name, 1, e1});
        q.push_back('{name, 2, e2});
        -> smp;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        writeEnable = 1; writeAddr = a; writeData = d;
        @(negedge clk);
        writeEnable = 0;
    endtask

    initial begin
        rst = 1; writeEnable = 0; writeAddr = 0; writeData = 0; readAddr1 = 0; readAddr2 = 0;
        @(negedge clk);
        chk("reset", 5, 31, 0, 0);
        rst = 0;
        wr(3, 32'h0000_0008);
        chk("write_read", 3, 3, 32'h0000_0008, 32'h0000_0008);
        writeEnable = 1; writeAddr = 0; writeData = 32'hFFFF_FFFF;
        chk("zero_pre", 0, 0, 0, 0);
        @(negedge clk);
        writeEnable = 0;
        chk("zero_reg", 0, 3, 0, 32'h0000_0008);
        writeAddr = 5; writeData = 32'h1234_5678;
        @(negedge clk);
        chk("enable", 5, 5, 0, 0);
        writeAddr = 3; writeData = 'x;
        @(negedge clk);
        chk("x_data", 3, 5, 32'h0000_0008, 0);
        wr(7, 32'hDEAD_BEEF);
        chk("pre_reset", 7, 3, 32'hDEAD_BEEF, 32'h0000_0008);
        rst = 1;
        writeEnable = 1; writeAddr = 4; writeData = 32'h0000_00AA;
        chk("async_reset", 7, 3, 0, 0);
        @(negedge clk);
        rst = 0; writeEnable = 0;
        chk("reset_wins", 4, 7, 0, 0);
        wr(4, 32'h0000_0055);
        chk("first_write", 4, 3, 32'h0000_0055, 0);
        wr(9, 32'h1);
        writeEnable = 1; writeAddr = 9; writeData = 32'h2;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle", 4, 9, 32'h0000_0055, 32'h2);
`else
        chk("same_cycle", 4, 9, 32'h0000_0055, 32'h1);
`endif
        @(negedge clk);
        writeEnable = 0;
        chk("after_edge", 9, 9, 32'h2, 32'h2);
        for (int i = 1; i <= 7; i++) begin
            writeEnable = 1; writeAddr = 5'(i); writeData = 32'(8 - i);
            @(negedge clk);
        end
        writeEnable = 0;
        for (int i = 0; i <= 7; i++)
            chk("sweep", 5'(i), 5'(i), (i == 0) ? 0 : 32'(8 - i), (i == 0) ? 0 : 32'(8 - i));
        chk("independent", 2, 6, 32'd6, 32'd2);
        for (int i = 10; i <= 13; i++) begin
            writeEnable = 1; writeAddr = 5'(i); writeData = 32'(100 + i);
            @(negedge clk);
        end
        #2 rst = 1;
        #1 rst = 0;
        writeEnable = 0;
        chk("burst_reset_a", 10, 13, 0, 0);
        chk("burst_reset_b", 1, 9, 0, 0);
        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
